// File: rtl/goertzel_power_detect.sv
// Goertzel result power detector: squares {Re,Im}, sums 2^LOG2_NAVG powers into a frame,
// presents the frame on an AXI4-Stream host port and pulses o_trigger when it exceeds i_threshold.
module goertzel_power_detect #(
  parameter int IW        = 20,
  parameter int LOG2_NAVG = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [2*IW-1:0]           s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [2*IW+LOG2_NAVG-1:0] i_threshold,
  output logic [2*IW+LOG2_NAVG-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      o_trigger
);

  localparam int PW = 2 * IW;
  localparam int AW = PW + LOG2_NAVG;
  localparam int CW = LOG2_NAVG + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'((1 << LOG2_NAVG) - 1);

  typedef enum logic [1:0] {
    ST_ACCUM,
    ST_FLUSH,
    ST_HOLD
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   count;
  logic [1:0]      flush_cnt;
  logic            s_hs, m_hs, flush_done;

  logic signed [IW-1:0] re_in, im_in;
  logic signed [PW-1:0] re_ext, im_ext;
  logic [PW-1:0]        re_sq, im_sq, pow_sum;
  logic                 v1, v2;
  logic [AW-1:0]        acc;

  assign s_axis_tready = (state == ST_ACCUM) && !i_rst;
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign m_hs          = m_axis_tvalid && m_axis_tready;
  // Four flush cycles give the last accepted sample time to drain through E1..E3.
  assign flush_done    = (state == ST_FLUSH) && (flush_cnt == 2'd3);

  assign re_in  = s_axis_tdata[2*IW-1:IW];
  assign im_in  = s_axis_tdata[IW-1:0];
  assign re_ext = {{IW{re_in[IW-1]}}, re_in};
  assign im_ext = {{IW{im_in[IW-1]}}, im_in};

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_ACCUM;
    else       state <= state_nxt;
  end

  // NOTE: next-state defaults to the current state first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_ACCUM: if (s_hs && (count == LAST_IDX)) state_nxt = ST_FLUSH;
      ST_FLUSH: if (flush_cnt == 2'd3)           state_nxt = ST_HOLD;
      ST_HOLD:  if (m_hs)                        state_nxt = ST_ACCUM;
      default:                                   state_nxt = ST_ACCUM;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count     <= '0;
      flush_cnt <= '0;
    end else begin
      if (m_hs)      count <= '0;
      else if (s_hs) count <= count + 1'b1;
      flush_cnt <= (state == ST_FLUSH) ? flush_cnt + 2'd1 : 2'd0;
    end
  end

  // NOTE: only the valid tags and accumulator need reset; data registers are ignored until tagged valid.
  always_ff @(posedge i_clk) begin
    re_sq   <= re_ext * re_ext;
    im_sq   <= im_ext * im_ext;
    pow_sum <= re_sq + im_sq;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      acc <= '0;
    end else begin
      v1 <= s_hs;
      v2 <= v1;
      if (m_hs)    acc <= '0;
      else if (v2) acc <= acc + AW'(pow_sum);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      o_trigger     <= 1'b0;
    end else begin
      o_trigger <= flush_done && (acc > i_threshold);
      if (flush_done) begin
        m_axis_tdata  <= acc;
        m_axis_tvalid <= 1'b1;
      end else if (m_hs) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule
